// File: rtl/fetch_decode_pipe.sv
// Fetch stage PC, IF/ID pipeline register, ID/EX control register and a
// stall watchdog. Optional macro FETCH_STALL_COUNT_EN adds the Stall_count
// port and a 16-bit saturating count of all stall cycles.
module fetch_decode_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_write,
    input  logic        IF_ID_write,
    input  logic        ID_EX_FLUSH,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic [31:0] IMem_data,
    input  logic [7:0]  ID_ctrl,
    output logic [31:0] IMem_addr,
    output logic [31:0] ID_instr,
    output logic [31:0] ID_PC4,
    output logic        ID_valid,
    output logic [7:0]  EX_ctrl,
    output logic        Stall_err
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [15:0] Stall_count
`endif
);

    typedef enum logic {RUN, STALL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic [7:0]  ex_ctrl_q, ex_ctrl_d;
    logic [3:0]  stall_cnt_q, stall_cnt_d;
    logic        stall_err_q, stall_err_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // PC, IF/ID and ID/EX next-state; each write enable acts independently
    always_comb begin
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        if (PC_write) begin
            pc_d = Branch_taken ? (Branch_target & 32'hFFFF_FFFC) : pc_plus4;
        end
        if (IF_ID_write) begin
            id_pc4_d   = pc_plus4;
            id_instr_d = Branch_taken ? '0 : IMem_data;
            id_valid_d = !Branch_taken;
        end
        ex_ctrl_d = ID_EX_FLUSH ? '0 : ID_ctrl;
    end

    // Stall FSM and watchdog; the consecutive counter is always 0 in RUN,
    // so the first stall edge out of RUN loads 1 directly
    always_comb begin
        state_d     = PC_write ? RUN : STALL;
        stall_cnt_d = '0;
        if (!PC_write) begin
            if (state_q == RUN)
                stall_cnt_d = 4'd1;
            else if (stall_cnt_q == 4'd15)
                stall_cnt_d = stall_cnt_q;
            else
                stall_cnt_d = stall_cnt_q + 4'd1;
        end
        stall_err_d = stall_err_q | (!PC_write && (stall_cnt_d == 4'd15));
    end

    // Pipeline and watchdog registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= '0;
            id_instr_q  <= '0;
            id_pc4_q    <= '0;
            id_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_instr_q  <= id_instr_d;
            id_pc4_q    <= id_pc4_d;
            id_valid_q  <= id_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign IMem_addr = pc_q;
    assign ID_instr  = id_instr_q;
    assign ID_PC4    = id_pc4_q;
    assign ID_valid  = id_valid_q;
    assign EX_ctrl   = ex_ctrl_q;
    assign Stall_err = stall_err_q;

`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_total_q, stall_total_d;

    // Cumulative stall cycles, saturating
    always_comb begin
        stall_total_d = stall_total_q;
        if (!PC_write && (stall_total_q != 16'hFFFF))
            stall_total_d = stall_total_q + 16'd1;
    end

    // Cumulative stall counter register
    always_ff @(posedge clk) begin
        if (rst)
            stall_total_q <= '0;
        else
            stall_total_q <= stall_total_d;
    end

    assign Stall_count = stall_total_q;
`endif

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Scoreboard bench for fetch_decode_pipe: the driver pushes the hand-computed
// expected register state after each clock edge, a negedge monitor pops and
// compares. Build with FETCH_STALL_COUNT_EN to also check Stall_count.
module tb_fetch_decode_pipe;

    logic        clk, rst, PC_write, IF_ID_write, ID_EX_FLUSH, Branch_taken;
    logic [31:0] Branch_target, IMem_data;
    logic [7:0]  ID_ctrl;
    logic [31:0] IMem_addr, ID_instr, ID_PC4;
    logic        ID_valid, Stall_err;
    logic [7:0]  EX_ctrl;
`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] Stall_count;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [7:0]  ctrl;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t e;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    fetch_decode_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .PC_write     (PC_write),
        .IF_ID_write  (IF_ID_write),
        .ID_EX_FLUSH  (ID_EX_FLUSH),
        .Branch_taken (Branch_taken),
        .Branch_target(Branch_target),
        .IMem_data    (IMem_data),
        .ID_ctrl      (ID_ctrl),
        .IMem_addr    (IMem_addr),
        .ID_instr     (ID_instr),
        .ID_PC4       (ID_PC4),
        .ID_valid     (ID_valid),
        .EX_ctrl      (EX_ctrl),
        .Stall_err    (Stall_err)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .Stall_count  (Stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: registered outputs are stable at the negedge following the push
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("IMem_addr", IMem_addr, x.pc);
            chk("ID_instr", ID_instr, x.instr);
            chk("ID_PC4", ID_PC4, x.pc4);
            chk("ID_valid", {31'd0, ID_valid}, {31'd0, x.valid});
            chk("EX_ctrl", {24'd0, EX_ctrl}, {24'd0, x.ctrl});
            chk("Stall_err", {31'd0, Stall_err}, {31'd0, x.err});
`ifdef FETCH_STALL_COUNT_EN
            chk("Stall_count", {16'd0, Stall_count}, {16'd0, x.cnt});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1; PC_write = 1'b1; IF_ID_write = 1'b1; ID_EX_FLUSH = 1'b0;
        Branch_taken = 1'b0; Branch_target = '0; IMem_data = 32'h2008_0005; ID_ctrl = 8'h11;

        // reset for two cycles
        e = '0;
        tick();
        tick();

        // sequential fetch from 0
        rst = 1'b0;
        e.pc = 32'h4;  e.instr = 32'h2008_0005; e.pc4 = 32'h4; e.valid = 1'b1; e.ctrl = 8'h11;
        tick();
        e.pc = 32'h8;  e.pc4 = 32'h8;  tick();
        e.pc = 32'hC;  e.pc4 = 32'hC;  tick();
        e.pc = 32'h10; e.pc4 = 32'h10; tick();

        // load-use stall with bubble
        PC_write = 1'b0; IF_ID_write = 1'b0; ID_EX_FLUSH = 1'b1; ID_ctrl = 8'hA5;
        IMem_data = 32'hDEAD_BEEF;
        e.ctrl = 8'h00; e.cnt = 16'd1;
        tick();
        PC_write = 1'b1; IF_ID_write = 1'b1; ID_EX_FLUSH = 1'b0;
        e.pc = 32'h14; e.instr = 32'hDEAD_BEEF; e.pc4 = 32'h14; e.ctrl = 8'hA5;
        tick();

        IMem_data = 32'h00A5_0513;
        e.instr = 32'h00A5_0513;
        e.pc = 32'h18; e.pc4 = 32'h18; tick();
        e.pc = 32'h1C; e.pc4 = 32'h1C; tick();
        e.pc = 32'h20; e.pc4 = 32'h20; tick();

        // taken branch, target low bits dropped, wrong-path flush
        Branch_taken = 1'b1; Branch_target = 32'h0000_0043;
        e.pc = 32'h40; e.instr = '0; e.valid = 1'b0; e.pc4 = 32'h24;
        tick();
        Branch_taken = 1'b0;
        e.pc = 32'h44; e.instr = 32'h00A5_0513; e.valid = 1'b1; e.pc4 = 32'h44;
        tick();

        // branch while PC stalled: PC holds, IF/ID still flushes
        PC_write = 1'b0; Branch_taken = 1'b1; Branch_target = 32'h100;
        e.instr = '0; e.valid = 1'b0; e.pc4 = 32'h48; e.cnt = 16'd2;
        tick();
        Branch_taken = 1'b0; IF_ID_write = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            e.err = (k >= 15);
            e.cnt = 16'(1 + k);
            tick();
        end

        // release: watchdog stays set
        PC_write = 1'b1; IF_ID_write = 1'b1;
        e.pc = 32'h48; e.instr = 32'h00A5_0513; e.pc4 = 32'h48; e.valid = 1'b1;
        tick();

        // reset clears the sticky error
        rst = 1'b1;
        e = '0;
        tick();
        rst = 1'b0;

        // PC wrap
        Branch_taken = 1'b1; Branch_target = 32'hFFFF_FFFF;
        e.pc = 32'hFFFF_FFFC; e.pc4 = 32'h4; e.instr = '0; e.valid = 1'b0; e.ctrl = 8'hA5;
        tick();
        Branch_taken = 1'b0;
        e.pc = 32'h0; e.pc4 = 32'h0; e.instr = 32'h00A5_0513; e.valid = 1'b1;
        tick();

        // three stall cycles
        PC_write = 1'b0; IF_ID_write = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            e.cnt = 16'(k);
            tick();
        end

        // reset mid-stall with a simultaneous branch
        rst = 1'b1; Branch_taken = 1'b1; Branch_target = 32'h80; IF_ID_write = 1'b1;
        e = '0;
        tick();
        rst = 1'b0; Branch_taken = 1'b0; PC_write = 1'b1;
        e.pc = 32'h4; e.pc4 = 32'h4; e.instr = 32'h00A5_0513; e.valid = 1'b1; e.ctrl = 8'hA5;
        tick();

        // bounded drain of the scoreboard
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_decode_pipe.md
FETCH_DECODE_PIPE -- requirements
Module: Fetch_Decode_Pipe

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- PC_write  input  1  1 = PC may update; 0 = hold PC (stall).
- IF_ID_write  input  1  1 = IF/ID register may load; 0 = hold.
- ID_EX_FLUSH  input  1  1 = insert bubble into ID/EX control.
- Branch_taken  input  1  branch resolved taken in ID this cycle.
- Branch_target  input  32  byte address of taken branch.
- IMem_data  input  32  instruction at IMem_addr; combinational read.
- ID_ctrl  input  8  decoded control bits of the instruction in ID.
- IMem_addr  output  32  current PC, drives instruction memory.
- ID_instr  output  32  IF/ID instruction register.
- ID_PC4  output  32  IF/ID PC+4 register.
- ID_valid  output  1  IF/ID holds a real instruction.
- EX_ctrl  output  8  ID/EX control register.
- Stall_err  output  1  watchdog: stall exceeded limit.
- Stall_count  output  16  cumulative stall cycles (only with STALL_COUNT_EN).

Function
REQ-002 SHALL hold the PC in a 32-bit register driven directly onto IMem_addr.
REQ-003 SHALL load PC with {Branch_target[31:2],2'b00} when PC_write=1 and Branch_taken=1.
REQ-004 SHALL load PC with PC+4 when PC_write=1 and Branch_taken=0; 0xFFFFFFFC wraps to 0x00000000.
REQ-005 SHALL hold PC when PC_write=0, ignoring Branch_taken in that cycle.
REQ-006 SHALL, when IF_ID_write=1 and Branch_taken=1, load ID_instr=0x00000000, ID_valid=0 and ID_PC4=PC+4 (wrong-path flush).
REQ-007 SHALL, when IF_ID_write=1 and Branch_taken=0, load ID_instr=IMem_data, ID_PC4=PC+4, ID_valid=1.
REQ-008 SHALL hold ID_instr, ID_PC4 and ID_valid when IF_ID_write=0.
REQ-009 SHALL load EX_ctrl=8'h00 when ID_EX_FLUSH=1, else EX_ctrl=ID_ctrl; ID_EX_FLUSH does not affect PC or IF/ID.
REQ-010 SHALL give a one-cycle latency from IMem_data to ID_instr and from ID_ctrl to EX_ctrl.
REQ-011 SHALL implement a 2-state FSM: RUN (PC_write=1 last cycle) and STALL (PC_write=0); RUN->STALL on PC_write=0, STALL->RUN on PC_write=1.
REQ-012 SHALL keep a 4-bit consecutive-stall counter: increments each edge in which PC_write=0, saturates at 15, clears on PC_write=1.
REQ-013 SHALL register Stall_err=1 on the edge where the counter reaches 15 with PC_write still 0; Stall_err stays 1 (sticky) until rst.
REQ-014 SHALL treat PC_write=1 with IF_ID_write=0 (and the converse) independently per REQ-003 to REQ-008; no cross-gating.

Reset
REQ-015 SHALL, on rising clk with rst=1, set PC=0x00000000, ID_instr=0, ID_PC4=0, ID_valid=0, EX_ctrl=0, FSM=RUN, stall counter=0, Stall_err=0, Stall_count=0.
REQ-016 SHALL give rst priority over every other input, including mid-stall and a simultaneous Branch_taken.
REQ-017 SHALL present IMem_addr=0x00000000 in the first cycle after rst deasserts.

Configuration
REQ-018 SHALL compile the Stall_count port and its 16-bit counter only when macro FETCH_STALL_COUNT_EN is defined; counter increments each edge with PC_write=0 and saturates at 0xFFFF.
REQ-019 SHALL, without FETCH_STALL_COUNT_EN, omit the Stall_count port and counter with all other behaviour unchanged.

Verification
REQ-020 Bench SHALL cover: rst 2 cycles, PC_write=IF_ID_write=1, IMem_data=0x20080005 -> IMem_addr 0,4,8; ID_instr=0x20080005, ID_PC4=4, ID_valid=1 one cycle later.
REQ-021 Bench SHALL cover: load-use stall, PC=0x10, PC_write=IF_ID_write=0, ID_EX_FLUSH=1 for 1 cycle, ID_ctrl=8'hA5 -> PC holds 0x10, IF/ID holds, EX_ctrl=0x00, then 0xA5 next cycle.
REQ-022 Bench SHALL cover: Branch_taken=1, Branch_target=0x00000043, PC=0x20 -> PC=0x40, ID_instr=0, ID_valid=0.
REQ-023 Bench SHALL cover: Branch_taken=1 with PC_write=0 -> PC unchanged; PC_write=0 for 16 cycles -> Stall_err=1 from 15th stall edge, sticky after PC_write=1, cleared by rst.
REQ-024 Bench SHALL cover: PC forced to 0xFFFFFFFC via branch, then one run cycle -> PC=0x00000000; with FETCH_STALL_COUNT_EN, 3 stall cycles -> Stall_count=3.
REQ-025 Bench SHALL cover: rst asserted during a stall with Branch_taken=1 -> all state equals REQ-015 values next edge.
